// File: rtl/seq_alu_if.sv
// seq_alu_if: start/busy/done handshake and operand/result bus for seq_alu
interface seq_alu_if #(parameter int SIZE = 16);
  logic            start;
  logic [3:0]      operation;
  logic [SIZE-1:0] primaryOperand;
  logic [SIZE-1:0] secondaryOperand;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] result;
  logic [SIZE-1:0] resultHigh;
  logic [3:0]      flags;
  modport master (
    output start, operation, primaryOperand, secondaryOperand,
    input  busy, done, result, resultHigh, flags
  );
  modport slave (
    input  start, operation, primaryOperand, secondaryOperand,
    output busy, done, result, resultHigh, flags
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arith ops and shift-add multiply / restoring divide
module seq_alu #(parameter int SIZE = 16) (
  input logic     clock,
  input logic     reset,
  seq_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_NOT = 4'd4, OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_MUL = 4'd8, OP_DIV = 4'd9;
  state_t state, next_state;
  logic [SIZE-1:0] opa, opb, a, hi, lo, nhi, nlo;
  logic [3:0] op;
  logic [CW-1:0] cnt;
  logic issue, multi, last, mul_v;
  logic [SIZE:0] add, sub, mul_sum, div_shift, div_diff;
  logic [SIZE-1:0] alu_res, alu_hi;
  logic alu_c, alu_v, alu_def, div_ge;
  assign opa = bus.primaryOperand;
  assign opb = bus.secondaryOperand;
  assign op = bus.operation;
  assign issue = (state == IDLE) && bus.start;
  assign multi = (op == OP_MUL) || (op == OP_DIV && |opb);
  assign last = (state != IDLE) && (cnt == CW'(1));
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (issue && op == OP_MUL) next_state = MUL_RUN;
    else if (issue && op == OP_DIV && |opb) next_state = DIV_RUN;
    else if (last) next_state = IDLE;
  end
  always_comb bus.busy = (state != IDLE);
  always_comb begin
    add = {1'b0, opa} + {1'b0, opb};
    sub = {1'b0, opa} - {1'b0, opb};
    alu_res = '0;
    alu_hi = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_def = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = add[SIZE-1:0];
        alu_c = add[SIZE];
        alu_v = (opa[SIZE-1] == opb[SIZE-1]) && (add[SIZE-1] != opa[SIZE-1]);
      end
      OP_SUB: begin
        alu_res = sub[SIZE-1:0];
        alu_c = sub[SIZE];
        alu_v = (opa[SIZE-1] != opb[SIZE-1]) && (sub[SIZE-1] != opa[SIZE-1]);
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_NOT: alu_res = ~opa;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: begin
        alu_res = {opa[SIZE-2:0], 1'b0};
        alu_c = opa[SIZE-1];
        alu_v = opa[SIZE-1] ^ opa[SIZE-2];
      end
      OP_SHR: begin
        alu_res = {1'b0, opa[SIZE-1:1]};
        alu_c = opa[0];
      end
      // only reached single-cycle when the divisor is zero
      OP_DIV: begin
        alu_res = '1;
        alu_hi = opa;
        alu_v = 1'b1;
      end
      default: alu_def = 1'b0;
    endcase
  end
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    div_shift = {hi, lo[SIZE-1]};
    div_diff = div_shift - {1'b0, a};
    div_ge = !div_diff[SIZE];
    nhi = (state == MUL_RUN) ? mul_sum[SIZE:1] : (div_ge ? div_diff[SIZE-1:0] : div_shift[SIZE-1:0]);
    nlo = (state == MUL_RUN) ? {mul_sum[0], lo[SIZE-1:1]} : {lo[SIZE-2:0], div_ge};
    mul_v = (state == MUL_RUN) && |nhi;
  end
  // a holds multiplicand or divisor; lo shifts out multiplier / dividend and fills with product / quotient
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      a <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.resultHigh <= '0;
      bus.flags <= '0;
    end else begin
      bus.done <= (issue && !multi) || last;
      if (issue && multi) begin
        a <= (op == OP_MUL) ? opa : opb;
        hi <= '0;
        lo <= (op == OP_MUL) ? opb : opa;
        cnt <= CW'(SIZE);
      end else if (state != IDLE) begin
        hi <= nhi;
        lo <= nlo;
        cnt <= cnt - CW'(1);
      end
      if (issue && !multi) begin
        bus.result <= alu_res;
        bus.resultHigh <= alu_hi;
        bus.flags <= {alu_v, alu_def && (alu_res == '0), alu_c, alu_res[SIZE-1]};
      end else if (last) begin
        bus.result <= nlo;
        bus.resultHigh <= nhi;
        bus.flags <= {mul_v, nlo == '0, mul_v, nlo[SIZE-1]};
      end
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Adds a start/busy/done handshake, registered result and flags, XOR and shift operations, and multi-cycle unsigned multiply and divide. Multiply uses shift-add; divide uses restoring division.
- Sits between the register file and the writeback stage. The controller issues one operation at a time and waits for done.

Parameters:
- SIZE, 16, operand/result width in bits; must be ≥ 4.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- operation  input  4  opcode, captured with start
- primaryOperand  input  SIZE  operand A / dividend / multiplicand
- secondaryOperand  input  SIZE  operand B / divisor / multiplier
- busy  output  1  high while a multi-cycle operation runs
- done  output  1  one-cycle pulse when result and flags are valid
- result  output  SIZE  low result / quotient
- resultHigh  output  SIZE  product high half / remainder; 0 for other ops
- flags  output  4  [3] overflow, [2] zero, [1] carry, [0] negative

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0; done=0; result=0; resultHigh=0; flags=4'b0000.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 COMPLEMENT (~A), 5 XOR
  - 6 SHL (A<<1), 7 SHR (A>>1, logical)
  - 8 MUL, 9 DIV
  - 10–15 are undefined: result=0, resultHigh=0, flags=0, single-cycle.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
  - IDLE & start & op∈{0..7,10..15}: compute from the sampled inputs; register outputs at that edge; done=1 for the next cycle; stay in IDLE.
  - IDLE & start & op=8: capture operands; busy=1; go to MUL_RUN; iteration counter=SIZE.
  - IDLE & start & op=9 & B≠0: capture operands; busy=1; go to DIV_RUN; counter=SIZE.
  - IDLE & start & op=9 & B=0: single-cycle; result={SIZE{1}}; resultHigh=A; overflow=1; carry=0.
  - MUL_RUN / DIV_RUN: one iteration per clock. After SIZE iterations, register outputs, busy=0, done=1 for one cycle, return to IDLE.
- Latency:
  - single-cycle ops: done high on the cycle after the start edge.
  - MUL/DIV: busy high for exactly SIZE cycles; done high in the cycle after busy falls. Total is SIZE+1 cycles from start edge to done.
- start while busy=1 is ignored; no queueing. start held high in IDLE re-issues every cycle.
- Operands may change after the start edge; only the captured copies are used.
- result, resultHigh and flags hold their values until the next operation completes. They do not change during busy.
- Flags:
  - ADD: carry=carry out of MSB; overflow=signed overflow (carry into MSB XOR carry out).
  - SUB: carry=borrow (A<B unsigned); overflow=signed overflow of A−B.
  - AND/OR/XOR/COMPLEMENT: carry=0, overflow=0.
  - SHL: carry=A[SIZE-1]; overflow=A[SIZE-1]^A[SIZE-2].
  - SHR: carry=A[0]; overflow=0.
  - MUL (unsigned, full 2·SIZE product): carry=overflow=(resultHigh≠0).
  - DIV (unsigned): carry=0; overflow=0 except on divide-by-zero.
  - All ops: zero=(result==0), based on the low word only; negative=result[SIZE-1].
- resultHigh is 0 for all ops except MUL and DIV.
- Reset asserted mid-operation aborts it immediately; no done pulse is produced; outputs go to their reset values.

Test Plan:
- Reset: assert reset mid-MUL (busy=1) -> busy, done, result, resultHigh and flags all 0 asynchronously; no done pulse after release.
- ADD 16'h7FFF+16'h0001 -> next cycle done=1, result=16'h8000, flags=4'b1001 (overflow, negative). Then ADD 16'hFFFF+16'h0001 -> result=0, flags=4'b0110 (zero, carry).
- SUB 16'h0003−16'h0005 -> result=16'hFFFE, flags=4'b0011 (carry=borrow, negative). SHL 16'hC001 -> result=16'h8002, flags=4'b0011.
- MUL 16'h1234×16'h0100 -> busy high 16 cycles, done at cycle 17, result=16'h3400, resultHigh=16'h0012, flags=4'b1010. A start pulse issued during busy has no effect.
- DIV 16'd1000÷16'd7 -> done at cycle 17, result=16'd142, resultHigh=16'd6, flags=4'b0000. DIV 16'd5÷0 -> done next cycle, result=16'hFFFF, resultHigh=16'd5, flags=4'b1001.
- Back-to-back single-cycle ops with start held high for 3 cycles (AND, OR, XOR) -> three consecutive done pulses, each result matching its inputs. Opcode 12 -> result=0, resultHigh=0, flags=0.
